rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
// - Shares the RTC multiplexed address/data bus among NREQ requesters: init/config,
//   periodic read-all, hour/date/chrono write sequencers.
// - Arbitrates; runs one timed bus transaction (address phase + data phase) per grant;
//   returns read data.
// - Sits between the top-level control FSM's sequencers and the RTC pins.
// PARAMETERS
// - NREQ   4  number of requesters; index 0 = highest fixed priority
// - T_SU   2  clocks of setup before each strobe (1..15)
// - T_STB  4  clocks strobe (wr_n/rd_n) held low (1..15)
// - T_HLD  2  clocks of hold after each strobe (1..15)
// PORTS
// - clock       in   1       system clock
// - reset       in   1       sync, active-high
// - req         in   NREQ    request per requester; level, held until done
// - we          in   NREQ    1 = write, 0 = read (per requester)
// - addr        in   8*NREQ  RTC register address, slice i = [8i+7:8i]
// - wdata       in   8*NREQ  write data, slice i
// - gnt         out  NREQ    one-hot grant, high from arbitration to done
// - done        out  NREQ    one-clock pulse at transaction end
// - rdata       out  8       read data; valid when done pulses, held until next read
// - busy        out  1       transaction in progress
// - cs_n, rd_n, wr_n  out 1  RTC strobes, active-low
// - ad_sel      out  1       RTC A/D pin: 0 = address phase, 1 = data phase
// - ad_out      out  8       bus drive value
// - ad_oe       out  1       tristate enable for ad_out (top-level IOBUF)
// - ad_in       in   8       bus sample value
// BEHAVIOUR
// - Reset: gnt=0, done=0, rdata=0, busy=0, cs_n=rd_n=wr_n=1, ad_sel=0, ad_out=0, ad_oe=0.
//   Reset mid-transaction aborts; strobes high after the next edge; no done.
// - FSM: IDLE -> A_SU -> A_STB -> A_HLD -> D_SU -> D_STB -> D_HLD -> DONE -> IDLE.
//   The phase counter reloads on every state entry.
// - IDLE: if |req, the winner is registered into gnt and busy=1 on the same edge.
//   The winner's we/addr/wdata are latched, so later changes are ignored.
// - A_*: cs_n=0, ad_sel=0, ad_oe=1, ad_out=addr; wr_n=0 only in A_STB (address latch).
// - D_*: cs_n=0, ad_sel=1. Write: ad_oe=1, ad_out=wdata, wr_n=0 in D_STB.
//   Read: ad_oe=0, rd_n=0 in D_STB; ad_in sampled into rdata on the last D_STB clock.
// - DONE: done[g]=1 for one clock, cs_n=1, ad_oe=0; then gnt=0, busy=0. IDLE lasts at
//   least 1 clock between transactions (bus turnaround).
// - Latency: done rises 2*(T_SU+T_STB+T_HLD) clocks after gnt rises; 16 with defaults.
// - req dropped mid-transaction: the transaction still completes and done still pulses.
// - Simultaneous requests: exactly one granted; the others wait, with no loss.
// - ad_oe and rd_n are never both active; strobes change only while cs_n=0 and ad is stable.
// CONFIGURATION
// - RTC_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. Search starts at last
//   granted index + 1 (mod NREQ); the pointer resets to NREQ-1, so index 0 wins first.
// - Not defined: fixed priority, lowest index wins. A continuous req[0] can starve
//   the others.
// STRUCTURE
// - rtc_bus_pkg: state encoding, RTC register address constants (seconds..year,
//   control, chrono), default timing constants.
// - Sub-module rtc_arb_pick: combinational one-hot picker (fixed / round-robin via
//   the macro), inputs req and last_gnt.
// - Top: FSM, phase counter, operand latches, pin registers (all outputs registered).
// TESTING
// - Single write: req[2]=1, we=1, addr=0x21, wdata=0x45. Expect gnt=0100; ad_out=0x21
//   with wr_n low 4 clocks; then ad_sel=1, ad_out=0x45, wr_n low; done[2] 16 clocks
//   after gnt.
// - Single read: req[1], addr=0x24, ad_in=0x16 during D_STB. Expect rd_n low 4 clocks,
//   ad_oe=0, rdata=0x16 at done[1].
// - Contention, fixed priority: req=1111 held. Expect grant order 0,0,0... In RR build,
//   expect 0,1,2,3,0 with one idle clock between each.
// - Operand change: alter addr[15:8] and drop req[1] during A_STB. Expect the original
//   address still on the bus and done[1] still pulsed.
// - Reset during D_STB of a write. Expect cs_n=wr_n=1, ad_oe=0, gnt=0 the next clock,
//   and no done.
// - Timing sweep: T_SU=1, T_STB=1, T_HLD=1. Expect done 6 clocks after gnt and each
//   strobe low exactly 1 clock.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus arbiter: FSM states, RTC register map,
// default strobe timing and the per-phase dwell reload helper.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_SU  = 3'd1,
    ST_A_STB = 3'd2,
    ST_A_HLD = 3'd3,
    ST_D_SU  = 3'd4,
    ST_D_STB = 3'd5,
    ST_D_HLD = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  typedef enum logic [7:0] {
    RTC_SEC    = 8'h20,
    RTC_MIN    = 8'h21,
    RTC_HOUR   = 8'h22,
    RTC_DAY    = 8'h23,
    RTC_DATE   = 8'h24,
    RTC_MONTH  = 8'h25,
    RTC_YEAR   = 8'h26,
    RTC_CTRL   = 8'h27,
    RTC_CHRONO = 8'h28
  } rtc_reg_e;

  localparam int T_SU_DEF  = 2;
  localparam int T_STB_DEF = 4;
  localparam int T_HLD_DEF = 2;
  localparam int CNT_W     = 4;

  // Counter value loaded on entry to a state; the state is left when it reaches zero.
  function automatic logic [CNT_W-1:0] f_phase_load(input state_t s, input int su,
                                                    input int stb, input int hld);
    case (s)
      ST_A_SU,  ST_D_SU:  f_phase_load = CNT_W'(su - 1);
      ST_A_STB, ST_D_STB: f_phase_load = CNT_W'(stb - 1);
      ST_A_HLD, ST_D_HLD: f_phase_load = CNT_W'(hld - 1);
      default:            f_phase_load = {CNT_W{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester-side handshake and RTC pin bundle of the bus arbiter.
// The arbiter uses the slave modport; requesters/pin model use master.
interface rtc_bus_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [8*NREQ-1:0] addr;
  logic [8*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        rdata;
  logic              busy;
  logic              cs_n;
  logic              rd_n;
  logic              wr_n;
  logic              ad_sel;
  logic [7:0]        ad_out;
  logic              ad_oe;
  logic [7:0]        ad_in;

  modport master (
    output req, we, addr, wdata, ad_in,
    input  gnt, done, rdata, busy, cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
  );

  modport slave (
    input  req, we, addr, wdata, ad_in,
    output gnt, done, rdata, busy, cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_bus_arbiter_pick.sv
// One-hot request picker. Fixed priority (index 0 wins) by default;
// round-robin starting after the last grant when RTC_ARB_ROUND_ROBIN_EN is defined.
module rtc_arb_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [NREQ-1:0] i_last_gnt,
  output logic [NREQ-1:0] o_gnt
);

  // Two's-complement trick isolates the lowest set bit.
  function automatic logic [NREQ-1:0] f_lowest(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction

`ifdef RTC_ARB_ROUND_ROBIN_EN
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_masked;

  assign w_mask   = ~(i_last_gnt | (i_last_gnt - NREQ'(1)));
  assign w_masked = i_req & w_mask;
  assign o_gnt    = (|w_masked) ? f_lowest(w_masked) : f_lowest(i_req);
`else
  logic w_unused_last;

  assign w_unused_last = ^i_last_gnt;
  assign o_gnt         = f_lowest(i_req);
`endif

endmodule

// File: rtl/rtc_bus_arbiter.sv
// RTC multiplexed-bus arbiter: grants one requester, runs a timed address+data
// transaction, returns read data. Arbitration policy set by RTC_ARB_ROUND_ROBIN_EN.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int T_SU  = T_SU_DEF,
  parameter int T_STB = T_STB_DEF,
  parameter int T_HLD = T_HLD_DEF
) (
  input logic              clock,
  input logic              reset,
  rtc_bus_arbiter_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_phase_end;
  logic             w_start;

  logic [NREQ-1:0]  w_pick;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_last_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;

  logic             w_pick_we;
  logic [7:0]       w_pick_addr;
  logic [7:0]       w_pick_wdata;
  logic             r_we;
  logic [7:0]       r_addr;
  logic [7:0]       r_wdata;
  logic             w_cur_we;
  logic [7:0]       w_cur_addr;
  logic [7:0]       w_cur_wdata;
  logic [7:0]       r_rdata;

  logic             w_cs_n, w_rd_n, w_wr_n, w_ad_sel, w_ad_oe;
  logic [7:0]       w_ad_out;
  logic             r_cs_n, r_rd_n, r_wr_n, r_ad_sel, r_ad_oe;
  logic [7:0]       r_ad_out;

  rtc_arb_pick #(.NREQ(NREQ)) u_pick (
    .i_req      (bus.req),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_pick)
  );

  assign w_phase_end = (r_cnt == {CNT_W{1'b0}});
  assign w_start     = (r_state == ST_IDLE) && (|bus.req);

  // Operands of the picked requester, selected by its one-hot grant
  always_comb begin
    w_pick_we    = 1'b0;
    w_pick_addr  = 8'h00;
    w_pick_wdata = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      w_pick_we    = w_pick_we | (bus.we[i] & w_pick[i]);
      w_pick_addr  = w_pick_addr  | (bus.addr[8*i +: 8]  & {8{w_pick[i]}});
      w_pick_wdata = w_pick_wdata | (bus.wdata[8*i +: 8] & {8{w_pick[i]}});
    end
  end

  // Pins are registered from the next state, so the grant edge needs the live operands
  assign w_cur_we    = (r_state == ST_IDLE) ? w_pick_we    : r_we;
  assign w_cur_addr  = (r_state == ST_IDLE) ? w_pick_addr  : r_addr;
  assign w_cur_wdata = (r_state == ST_IDLE) ? w_pick_wdata : r_wdata;

  // Next state and dwell counter
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_start     ? ST_A_SU  : ST_IDLE;
      ST_A_SU:  w_state_nxt = w_phase_end ? ST_A_STB : ST_A_SU;
      ST_A_STB: w_state_nxt = w_phase_end ? ST_A_HLD : ST_A_STB;
      ST_A_HLD: w_state_nxt = w_phase_end ? ST_D_SU  : ST_A_HLD;
      ST_D_SU:  w_state_nxt = w_phase_end ? ST_D_STB : ST_D_SU;
      ST_D_STB: w_state_nxt = w_phase_end ? ST_D_HLD : ST_D_STB;
      ST_D_HLD: w_state_nxt = w_phase_end ? ST_DONE  : ST_D_HLD;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = f_phase_load(w_state_nxt, T_SU, T_STB, T_HLD);
    end else begin
      w_cnt_nxt = w_phase_end ? r_cnt : r_cnt - CNT_W'(1);
    end
  end

  // Pin values for the state being entered
  always_comb begin
    w_cs_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_ad_sel = 1'b0;
    w_ad_oe  = 1'b0;
    w_ad_out = 8'h00;
    case (w_state_nxt)
      ST_A_SU, ST_A_STB, ST_A_HLD: begin
        w_cs_n   = 1'b0;
        w_ad_oe  = 1'b1;
        w_ad_out = w_cur_addr;
        w_wr_n   = (w_state_nxt == ST_A_STB) ? 1'b0 : 1'b1;
      end
      ST_D_SU, ST_D_STB, ST_D_HLD: begin
        w_cs_n   = 1'b0;
        w_ad_sel = 1'b1;
        w_ad_oe  = w_cur_we;
        w_ad_out = w_cur_we ? w_cur_wdata : 8'h00;
        w_wr_n   = !((w_state_nxt == ST_D_STB) && w_cur_we);
        w_rd_n   = !((w_state_nxt == ST_D_STB) && !w_cur_we);
      end
      default: begin
        w_cs_n = 1'b1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant, completion and operand latches; pointer starts at NREQ-1 so index 0 wins first
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt      <= {NREQ{1'b0}};
      r_last_gnt <= {1'b1, {(NREQ-1){1'b0}}};
      r_done     <= {NREQ{1'b0}};
      r_busy     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 8'h00;
      r_wdata    <= 8'h00;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= (w_state_nxt == ST_DONE) ? r_gnt : {NREQ{1'b0}};
      if (w_start) begin
        r_gnt      <= w_pick;
        r_last_gnt <= w_pick;
        r_we       <= w_pick_we;
        r_addr     <= w_pick_addr;
        r_wdata    <= w_pick_wdata;
      end else if (r_state == ST_DONE) begin
        r_gnt <= {NREQ{1'b0}};
      end
    end
  end

  // RTC pin registers and read capture on the last strobe clock
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_sel <= 1'b0;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
      r_rdata  <= 8'h00;
    end else begin
      r_cs_n   <= w_cs_n;
      r_rd_n   <= w_rd_n;
      r_wr_n   <= w_wr_n;
      r_ad_sel <= w_ad_sel;
      r_ad_oe  <= w_ad_oe;
      r_ad_out <= w_ad_out;
      if ((r_state == ST_D_STB) && w_phase_end && !r_we) begin
        r_rdata <= bus.ad_in;
      end
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.rdata  = r_rdata;
  assign bus.cs_n   = r_cs_n;
  assign bus.rd_n   = r_rd_n;
  assign bus.wr_n   = r_wr_n;
  assign bus.ad_sel = r_ad_sel;
  assign bus.ad_oe  = r_ad_oe;
  assign bus.ad_out = r_ad_out;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: default-timing instance plus a
// 1/1/1 timing instance, checked cycle by cycle against a transaction model.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  localparam int N = 4;
  // {cs_n, ad_sel, ad_oe, wr_n, rd_n, busy, gnt[3:0], done[3:0]}
  localparam logic [13:0] PINS_IDLE = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000};

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  rtc_bus_arbiter_if #(.NREQ(N)) bus ();
  rtc_bus_arbiter_if #(.NREQ(N)) bus2 ();

  rtc_bus_arbiter #(.NREQ(N)) dut (.clock(clock), .reset(reset), .bus(bus));
  rtc_bus_arbiter #(.NREQ(N), .T_SU(1), .T_STB(1), .T_HLD(1)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2));

  // Reference model state
  bit   [N-1:0] m_pend;
  bit   [N-1:0] m_we;
  logic [7:0]   m_addr [N];
  logic [7:0]   m_wdata [N];
  logic [7:0]   m_rdata [2];
  int           m_last;

  function automatic logic [13:0] pins(input bit sel);
    if (sel) return {bus2.cs_n, bus2.ad_sel, bus2.ad_oe, bus2.wr_n, bus2.rd_n, bus2.busy, bus2.gnt, bus2.done};
    else     return {bus.cs_n, bus.ad_sel, bus.ad_oe, bus.wr_n, bus.rd_n, bus.busy, bus.gnt, bus.done};
  endfunction

  function automatic logic [7:0] get_ad_out(input bit sel);
    return sel ? bus2.ad_out : bus.ad_out;
  endfunction

  function automatic logic [7:0] get_rdata(input bit sel);
    return sel ? bus2.rdata : bus.rdata;
  endfunction

  function automatic int predict();
    int w;
    w = -1;
`ifdef RTC_ARB_ROUND_ROBIN_EN
    for (int k = N; k >= 1; k--) if (m_pend[(m_last + k) % N]) w = (m_last + k) % N;
`else
    for (int k = N - 1; k >= 0; k--) if (m_pend[k]) w = k;
`endif
    return w;
  endfunction

  task automatic drive(input bit sel, input int idx, input bit r, input bit w,
                       input logic [7:0] a, input logic [7:0] d);
    if (sel) begin
      bus2.req[idx] = r; bus2.we[idx] = w;
      bus2.addr[8*idx +: 8] = a; bus2.wdata[8*idx +: 8] = d;
    end else begin
      bus.req[idx] = r; bus.we[idx] = w;
      bus.addr[8*idx +: 8] = a; bus.wdata[8*idx +: 8] = d;
    end
  endtask

  task automatic set_req(input bit sel, input int idx, input bit r);
    if (sel) bus2.req[idx] = r;
    else     bus.req[idx] = r;
  endtask

  task automatic set_addr(input bit sel, input int idx, input logic [7:0] a);
    if (sel) bus2.addr[8*idx +: 8] = a;
    else     bus.addr[8*idx +: 8] = a;
  endtask

  task automatic set_ad_in(input bit sel, input logic [7:0] v);
    if (sel) bus2.ad_in = v;
    else     bus.ad_in = v;
  endtask

  task automatic wait_gnt(input bit sel, input int max_cyc, output int waited);
    waited = 0;
    while (waited < max_cyc) begin
      @(posedge clock); #1;
      waited++;
      if (pins(sel)[7:4] != 4'b0000) break;
    end
    checks++;
    if (pins(sel)[7:4] == 4'b0000) begin
      errors++;
      $display("FAIL gnt_timeout sel=%0d got gnt=0 after %0d clocks, required a grant", sel, waited);
    end
  endtask

  // Called in the first granted clock; walks the whole transaction plus one idle clock.
  task automatic check_txn(input bit sel, input int idx, input bit w, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] rv, input bit hold,
                           input bit perturb);
    int tsu, tstb, p, ph, o;
    bit stb;
    logic [3:0]  oh;
    logic [13:0] exp, msk;
    logic [7:0]  exp_bus;
    tsu  = sel ? 1 : 2;
    tstb = sel ? 1 : 4;
    p    = sel ? 3 : 8;
    oh   = 4'b0001 << idx;
    for (int k = 0; k <= 2*p + 1; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      ph  = k / p;
      o   = k % p;
      stb = (k < 2*p) && (o >= tsu) && (o < tsu + tstb);
      msk = 14'h3FFF;
      if (k < 2*p) begin
        exp = {1'b0, (ph == 1), (ph == 0) || w, !(stb && ((ph == 0) || w)),
               !(stb && (ph == 1) && !w), 1'b1, oh, 4'b0000};
      end else begin
        exp = {PINS_IDLE[13:9], (k == 2*p), (k == 2*p) ? oh : 4'b0000, (k == 2*p) ? oh : 4'b0000};
        msk = 14'h2FFF;
      end
      checks++;
      if ((pins(sel) & msk) !== (exp & msk)) begin
        errors++;
        $display("FAIL pins sel=%0d idx=%0d k=%0d got=%h required=%h", sel, idx, k, pins(sel) & msk, exp & msk);
      end
      if ((k < 2*p) && ((ph == 0) || w)) begin
        exp_bus = (ph == 0) ? a : d;
        checks++;
        if (get_ad_out(sel) !== exp_bus) begin
          errors++;
          $display("FAIL ad_out sel=%0d idx=%0d k=%0d got=%h required=%h", sel, idx, k, get_ad_out(sel), exp_bus);
        end
      end
      if (k == 2*p) begin
        if (!w) m_rdata[sel] = rv;
        checks++;
        if (get_rdata(sel) !== m_rdata[sel]) begin
          errors++;
          $display("FAIL rdata sel=%0d idx=%0d got=%h required=%h", sel, idx, get_rdata(sel), m_rdata[sel]);
        end
      end
      // RTC drives the read value only in the final strobe clock
      set_ad_in(sel, (!w && (k == p + tsu + tstb - 1)) ? rv : ~rv);
      if (perturb && (k == tsu)) begin
        set_addr(sel, idx, ~a);
        set_req(sel, idx, 1'b0);
      end
      if ((k == 2*p) && !hold) set_req(sel, idx, 1'b0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (pins(s[0]) !== PINS_IDLE || get_ad_out(s[0]) !== 8'h00 || get_rdata(s[0]) !== 8'h00) begin
        errors++;
        $display("FAIL reset sel=%0d got pins=%h ad_out=%h rdata=%h required pins=%h ad_out=00 rdata=00",
                 s, pins(s[0]), get_ad_out(s[0]), get_rdata(s[0]), PINS_IDLE);
      end
    end
    reset = 1'b0;
    m_last = N - 1;
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
  endtask

  task automatic test_single_write();
    int waited;
    drive(1'b0, 2, 1'b1, 1'b1, RTC_MIN, 8'h45);
    wait_gnt(1'b0, 40, waited);
    check_txn(1'b0, 2, 1'b1, RTC_MIN, 8'h45, 8'h00, 1'b0, 1'b0);
    m_last = 2;
  endtask

  task automatic test_single_read();
    int waited;
    drive(1'b0, 1, 1'b1, 1'b0, RTC_DATE, 8'h00);
    wait_gnt(1'b0, 40, waited);
    check_txn(1'b0, 1, 1'b0, RTC_DATE, 8'h00, 8'h16, 1'b0, 1'b0);
    m_last = 1;
  endtask

  task automatic test_contention();
    int waited, w;
    m_pend = '1;
    for (int i = 0; i < N; i++) begin
      m_we[i] = 1'($urandom); m_addr[i] = 8'($urandom); m_wdata[i] = 8'($urandom);
      drive(1'b0, i, 1'b1, m_we[i], m_addr[i], m_wdata[i]);
    end
    for (int t = 0; t < 5; t++) begin
      w = predict();
      wait_gnt(1'b0, 40, waited);
      checks++;
      if (waited != 1) begin
        errors++;
        $display("FAIL contention_gap t=%0d got %0d clocks to grant, required 1", t, waited);
      end
      check_txn(1'b0, w, m_we[w], m_addr[w], m_wdata[w], 8'($urandom), 1'b1, 1'b0);
      m_last = w;
    end
    for (int i = 0; i < N; i++) set_req(1'b0, i, 1'b0);
    m_pend = '0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_operand_change();
    int waited;
    bit w;
    logic [7:0] a, d;
    w = 1'($urandom); a = 8'($urandom); d = 8'($urandom);
    drive(1'b0, 1, 1'b1, w, a, d);
    wait_gnt(1'b0, 40, waited);
    check_txn(1'b0, 1, w, a, d, 8'($urandom), 1'b0, 1'b1);
    m_last = 1;
  endtask

  task automatic test_random();
    int waited, w;
    for (int r = 0; r < 12; r++) begin
      m_pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        m_we[i] = 1'($urandom); m_addr[i] = 8'($urandom); m_wdata[i] = 8'($urandom);
        drive(1'b0, i, m_pend[i], m_we[i], m_addr[i], m_wdata[i]);
      end
      while (m_pend != '0) begin
        w = predict();
        wait_gnt(1'b0, 40, waited);
        checks++;
        if (waited != 1) begin
          errors++;
          $display("FAIL back_to_back r=%0d got %0d clocks to grant, required 1", r, waited);
        end
        check_txn(1'b0, w, m_we[w], m_addr[w], m_wdata[w], 8'($urandom), 1'b0, 1'b0);
        m_pend[w] = 1'b0;
        m_last = w;
      end
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    bit seen;
    drive(1'b0, 3, 1'b1, 1'b1, RTC_HOUR, 8'h12);
    wait_gnt(1'b0, 40, waited);
    repeat (10) @(posedge clock);
    #1;
    checks++;
    if (bus.wr_n !== 1'b0 || bus.ad_sel !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_dstb got wr_n=%b ad_sel=%b required wr_n=0 ad_sel=1", bus.wr_n, bus.ad_sel);
    end
    reset = 1'b1;
    set_req(1'b0, 3, 1'b0);
    @(posedge clock); #1;
    checks++;
    if (pins(1'b0) !== PINS_IDLE) begin
      errors++;
      $display("FAIL reset_abort got pins=%h required=%h", pins(1'b0), PINS_IDLE);
    end
    reset = 1'b0;
    m_last = N - 1;
    m_rdata[0] = 8'h00;
    m_rdata[1] = 8'h00;
    seen = 1'b0;
    repeat (24) begin
      @(posedge clock); #1;
      if (bus.done !== 4'b0000 || bus.gnt !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_done got done/gnt activity after abort, required none");
    end
  endtask

  task automatic test_timing_sweep();
    int waited;
    drive(1'b1, 0, 1'b1, 1'b1, RTC_CTRL, 8'hA5);
    wait_gnt(1'b1, 40, waited);
    check_txn(1'b1, 0, 1'b1, RTC_CTRL, 8'hA5, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 3, 1'b1, 1'b0, RTC_CHRONO, 8'h00);
    wait_gnt(1'b1, 40, waited);
    check_txn(1'b1, 3, 1'b0, RTC_CHRONO, 8'h00, 8'h5C, 1'b0, 1'b0);
  endtask

  initial begin
    bus.req = '0;  bus.we = '0;  bus.addr = '0;  bus.wdata = '0;  bus.ad_in = '0;
    bus2.req = '0; bus2.we = '0; bus2.addr = '0; bus2.wdata = '0; bus2.ad_in = '0;
    m_pend = '0;
    m_last = N - 1;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_operand_change();
    test_random();
    test_reset_mid();
    test_timing_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
